// File: rtl/mlp_frame_sequencer.sv
// Sequencer around a combinational MLP classifier: packs a feature stream into a registered frame,
// waits for the classifier to settle, then returns the class index. Optional macro: MLP_FRAME_DOUBLE_SAMPLE_EN.
module mlp_frame_sequencer #(
  parameter int FEAT_W        = 4,
  parameter int N_FEAT        = 4,
  parameter int CLS_W         = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     feat_valid,
  input  logic [FEAT_W-1:0]        feat_data,
  input  logic                     feat_last,
  output logic                     feat_ready,
  output logic [FEAT_W*N_FEAT-1:0] mlp_inp,
  input  logic [CLS_W-1:0]         mlp_out,
  output logic                     cls_valid,
  output logic [CLS_W-1:0]         cls_data,
  input  logic                     cls_ready,
  output logic                     frame_err
`ifdef MLP_FRAME_DOUBLE_SAMPLE_EN
  ,
  output logic                     cls_unstable
`endif
);

  localparam int FRAME_W = FEAT_W * N_FEAT;
  localparam int CNT_W   = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int SET_W   = $clog2(SETTLE_CYCLES + 2);
`ifdef MLP_FRAME_DOUBLE_SAMPLE_EN
  localparam int LAST_SETTLE = SETTLE_CYCLES;
  localparam logic [SET_W-1:0] SAMPLE1_CNT = SET_W'(SETTLE_CYCLES - 1);
`else
  localparam int LAST_SETTLE = SETTLE_CYCLES - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_FEAT   = CNT_W'(N_FEAT - 1);
  localparam logic [SET_W-1:0] CAPTURE_CNT = SET_W'(LAST_SETTLE);

  typedef enum logic [1:0] {
    COLLECT,
    SETTLE,
    OUT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [FRAME_W-1:0]  shadow_q, shadow_d;
  logic [FRAME_W-1:0]  mlp_inp_q, mlp_inp_d;
  logic                cls_valid_q, cls_valid_d;
  logic [CLS_W-1:0]    cls_data_q, cls_data_d;
  logic                frame_err_q, frame_err_d;
  logic [FRAME_W-1:0]  launch_frame;
  logic                is_last_slot;
`ifdef MLP_FRAME_DOUBLE_SAMPLE_EN
  logic [CLS_W-1:0]    sample1_q, sample1_d;
  logic                unstable_q, unstable_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      count_q     <= '0;
      settle_q    <= '0;
      shadow_q    <= '0;
      mlp_inp_q   <= '0;
      cls_valid_q <= 1'b0;
      cls_data_q  <= '0;
      frame_err_q <= 1'b0;
`ifdef MLP_FRAME_DOUBLE_SAMPLE_EN
      sample1_q   <= '0;
      unstable_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      settle_q    <= settle_d;
      shadow_q    <= shadow_d;
      mlp_inp_q   <= mlp_inp_d;
      cls_valid_q <= cls_valid_d;
      cls_data_q  <= cls_data_d;
      frame_err_q <= frame_err_d;
`ifdef MLP_FRAME_DOUBLE_SAMPLE_EN
      sample1_q   <= sample1_d;
      unstable_q  <= unstable_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    settle_d     = settle_q;
    shadow_d     = shadow_q;
    mlp_inp_d    = mlp_inp_q;
    cls_valid_d  = cls_valid_q;
    cls_data_d   = cls_data_q;
    frame_err_d  = 1'b0;
`ifdef MLP_FRAME_DOUBLE_SAMPLE_EN
    sample1_d    = sample1_q;
    unstable_d   = unstable_q;
`endif
    is_last_slot = (count_q == LAST_FEAT);
    // The top slot of the shadow is never written; the last feature goes straight to mlp_inp.
    launch_frame = shadow_q;
    launch_frame[FRAME_W-1 -: FEAT_W] = feat_data;

    case (state_q)
      COLLECT: begin
        if (feat_valid) begin
          if (feat_last != is_last_slot) begin
            frame_err_d = 1'b1;
            count_d     = '0;
            shadow_d    = '0;
          end else if (is_last_slot) begin
            mlp_inp_d = launch_frame;
            count_d   = '0;
            settle_d  = '0;
            shadow_d  = '0;
            state_d   = SETTLE;
          end else begin
            for (int k = 0; k < N_FEAT - 1; k++) begin
              if (count_q == CNT_W'(k)) begin
                shadow_d[k*FEAT_W +: FEAT_W] = feat_data;
              end
            end
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      SETTLE: begin
        settle_d = settle_q + SET_W'(1);
`ifdef MLP_FRAME_DOUBLE_SAMPLE_EN
        if (settle_q == SAMPLE1_CNT) begin
          sample1_d = mlp_out;
        end
`endif
        if (settle_q == CAPTURE_CNT) begin
          cls_data_d  = mlp_out;
          cls_valid_d = 1'b1;
`ifdef MLP_FRAME_DOUBLE_SAMPLE_EN
          unstable_d  = (sample1_q != mlp_out);
`endif
          state_d     = OUT;
        end
      end
      OUT: begin
        if (cls_ready) begin
          cls_valid_d = 1'b0;
`ifdef MLP_FRAME_DOUBLE_SAMPLE_EN
          unstable_d  = 1'b0;
`endif
          state_d     = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  assign feat_ready = (state_q == COLLECT);
  assign mlp_inp    = mlp_inp_q;
  assign cls_valid  = cls_valid_q;
  assign cls_data   = cls_data_q;
  assign frame_err  = frame_err_q;
`ifdef MLP_FRAME_DOUBLE_SAMPLE_EN
  assign cls_unstable = unstable_q;
`endif

endmodule

// File: doc/mlp_frame_sequencer.md
Name: mlp_frame_sequencer

Overview:
- Sequential front/back end for the combinational fixed-point MLP classifier (16-bit packed feature input, 2-bit class index output).
- Assembles 4-bit features from a valid/ready stream into one packed frame and drives it to the classifier as a stable, registered vector.
- Waits a programmable settle time for the slow combinational path, then captures the class index and emits it on a valid/ready result interface.

Parameters:
- FEAT_W, 4, width of one feature in bits.
- N_FEAT, 4, features per frame; classifier input width = FEAT_W*N_FEAT.
- CLS_W, 2, width of the class index returned by the classifier.
- SETTLE_CYCLES, 3, clock edges between frame launch and class capture; legal range is 1 or more.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- feat_valid  in  1  feature word valid.
- feat_data  in  FEAT_W  feature value.
- feat_last  in  1  marks the final feature of a frame.
- feat_ready  out  1  sequencer accepts a feature.
- mlp_inp  out  FEAT_W*N_FEAT  registered packed frame to the classifier.
- mlp_out  in  CLS_W  classifier class index (combinational from mlp_inp).
- cls_valid  out  1  result valid.
- cls_data  out  CLS_W  captured class index.
- cls_ready  in  1  downstream accepts the result.
- frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset (asynchronous assert, any state): state=COLLECT, feature count=0, shadow=0, mlp_inp=0, cls_valid=0, cls_data=0, frame_err=0, feat_ready=1 once the FSM is in COLLECT.
- States: COLLECT, SETTLE, OUT. feat_ready = (state==COLLECT).
- COLLECT:
  - A feature is accepted on an edge where feat_valid & feat_ready are both high.
  - Feature k (k = 0 first) is written to shadow bits [FEAT_W*k+FEAT_W-1 : FEAT_W*k]. Feature 0 lands in [3:0]; feature 3 lands in [15:12].
  - Accepting feature k=N_FEAT-1 with feat_last=1 on the same edge: mlp_inp <= {that feature, shadow lower bits}, count <= 0, settle counter <= 0, state <= SETTLE.
  - mlp_inp changes only on this edge; it does not toggle during collection.
- Malformed frame (checked on the accepting edge):
  - feat_last=1 while k < N_FEAT-1, or feat_last=0 while k = N_FEAT-1.
  - Action: frame_err=1 for exactly one cycle; count <= 0; shadow discarded; mlp_inp unchanged; stay in COLLECT.
  - The erroneous word is consumed, not retried.
- SETTLE:
  - The counter increments on each edge.
  - On the edge where counter == SETTLE_CYCLES-1: cls_data <= mlp_out, cls_valid <= 1, state <= OUT.
  - cls_valid therefore rises exactly SETTLE_CYCLES edges after the last-feature acceptance edge.
- OUT:
  - cls_valid and cls_data are held stable until cls_ready=1.
  - On the handshake edge: cls_valid <= 0, state <= COLLECT. The next feature can be accepted on the following edge at the earliest.
  - feat_valid is ignored in SETTLE and OUT (feat_ready=0, no back-pressure loss).
  - mlp_inp holds the last frame until the next frame completes.
- Throughput: at most one frame per N_FEAT + SETTLE_CYCLES + 1 cycles.
- Width rule: mlp_inp is exactly FEAT_W*N_FEAT bits with no sign extension; features are unsigned.

Optional Feature:
- Macro: MLP_FRAME_DOUBLE_SAMPLE_EN.
- When defined:
  - Adds output port cls_unstable (1 bit).
  - SETTLE runs one extra edge. mlp_out is sampled at counter == SETTLE_CYCLES-1 and again at counter == SETTLE_CYCLES.
  - cls_data takes the second sample.
  - cls_unstable = (first sample != second sample). It is valid and held alongside cls_valid, and cleared with it.
  - Latency becomes SETTLE_CYCLES+1.
- When not defined: single sample, no cls_unstable port, latency SETTLE_CYCLES.

Test Plan:
- Nominal frame: features 0x3, 0x5, 0x9, 0xC (last on 0xC), stub mlp_out=2'b10, cls_ready=1 -> mlp_inp=16'hC953 on the 4th accept edge; cls_valid=1, cls_data=2'b10 exactly 3 edges later; back to COLLECT after 1 cycle.
- Back-pressure: same frame with cls_ready=0 for 10 cycles -> cls_valid/cls_data held, feat_ready=0 throughout, and feat_valid pulses ignored (mlp_inp unchanged); release -> single handshake.
- Early last: feat_last on 2nd feature -> frame_err pulse exactly 1 cycle, mlp_inp stays at its previous value; the next full frame 0x1, 0x2, 0x3, 0x4 -> mlp_inp=16'h4321.
- Missing last: 4th feature without feat_last -> frame_err pulse, no SETTLE entry, cls_valid stays 0.
- Reset mid-SETTLE: assert rst_n=0 one edge after frame launch -> all outputs 0 immediately (asynchronous); after release, a fresh frame completes normally.
- Macro on: stub changes mlp_out 2'b01 -> 2'b00 between the two samples -> cls_data=2'b00, cls_unstable=1, cls_valid at SETTLE_CYCLES+1=4 edges.
